// File: rtl/ultimate_attack.sv
// Ultimate-attack source: charges a meter, fires an expanding square blast around the
// owner on a fresh button press, and reports each enemy touched at most once per blast.
module ultimate_attack #(
   parameter int CHARGE_TICKS = 600,
   parameter int BLAST_STEP   = 2,
   parameter int BLAST_MAX    = 40,
   parameter int HOLD_TICKS   = 3
) (
   input  logic       debouncingclock,
   input  logic       reset,
   input  logic       btnult,
   input  logic [1:0] currentcharacter,
   input  logic [9:0] xcharacter,
   input  logic [9:0] ycharacter,
   input  logic [9:0] xmage,
   input  logic [9:0] ymage,
   input  logic [9:0] xgunman,
   input  logic [9:0] ygunman,
   input  logic [9:0] xswordman,
   input  logic [9:0] yswordman,
   input  logic [9:0] xfistman,
   input  logic [9:0] yfistman,
   output logic [9:0] charge_count,
   output logic       ult_ready,
   output logic       ult_active,
   output logic [9:0] blast_x0,
   output logic [9:0] blast_y0,
   output logic [9:0] blast_x1,
   output logic [9:0] blast_y1,
   output logic [3:0] ult_collisions
);

   typedef enum logic [1:0] {
      S_CHARGING = 2'd0,
      S_READY    = 2'd1,
      S_BLAST    = 2'd2,
      S_RECOVER  = 2'd3
   } state_t;

   localparam logic [9:0]  CHARGE_MAX = 10'(CHARGE_TICKS);
   localparam logic [10:0] STEP       = 11'(BLAST_STEP);
   localparam logic [10:0] RAD_MAX    = 11'(BLAST_MAX);
   localparam logic [9:0]  HOLD_LAST  = 10'(HOLD_TICKS - 1);

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_prev_btn;
   logic [10:0] r_cx;
   logic [10:0] r_cy;
   logic [10:0] r_rad;
   logic [3:0]  r_hit_mask;
   logic [9:0]  r_hold;
   logic        w_press;
   logic [10:0] w_x0;
   logic [10:0] w_y0;
   logic [10:0] w_x1;
   logic [10:0] w_y1;
   logic [10:0] w_xsum;
   logic [10:0] w_ysum;
   logic [3:0]  w_hit;
   logic [10:0] w_xk [4];
   logic [10:0] w_yk [4];

   assign w_press = btnult & ~r_prev_btn;

   assign w_xk[0] = {1'b0, xmage};
   assign w_yk[0] = {1'b0, ymage};
   assign w_xk[1] = {1'b0, xgunman};
   assign w_yk[1] = {1'b0, ygunman};
   assign w_xk[2] = {1'b0, xswordman};
   assign w_yk[2] = {1'b0, yswordman};
   assign w_xk[3] = {1'b0, xfistman};
   assign w_yk[3] = {1'b0, yfistman};

   // Blast box clamped to the 320x240 screen; 11-bit math so nothing wraps.
   always_comb begin
      w_xsum = r_cx + r_rad;
      w_ysum = r_cy + r_rad;
      w_x0   = (r_cx > r_rad) ? (r_cx - r_rad) : 11'd0;
      w_y0   = (r_cy > r_rad) ? (r_cy - r_rad) : 11'd0;
      w_x1   = (w_xsum > 11'd319) ? 11'd319 : w_xsum;
      w_y1   = (w_ysum > 11'd239) ? 11'd239 : w_ysum;
   end

   // Overlap of the box with each 20x20 character, never the owner.
   always_comb begin
      w_hit = 4'd0;
      for (int k = 0; k < 4; k++) begin
         if ((w_x0 < w_xk[k] + 11'd20) && (w_x1 > w_xk[k]) &&
             (w_y0 < w_yk[k] + 11'd20) && (w_y1 > w_yk[k]) &&
             (2'(k) != currentcharacter)) begin
            w_hit[k] = 1'b1;
         end else begin
            w_hit[k] = 1'b0;
         end
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_CHARGING: begin
            if (r_charge_next_full()) w_state_nxt = S_READY;
            else                      w_state_nxt = S_CHARGING;
         end
         S_READY: begin
            if (w_press) w_state_nxt = S_BLAST;
            else         w_state_nxt = S_READY;
         end
         S_BLAST: begin
            if (r_rad >= RAD_MAX) w_state_nxt = S_RECOVER;
            else                  w_state_nxt = S_BLAST;
         end
         S_RECOVER: begin
            if (r_hold == HOLD_LAST) w_state_nxt = S_CHARGING;
            else                     w_state_nxt = S_RECOVER;
         end
         default: w_state_nxt = S_CHARGING;
      endcase
   end

   function automatic logic r_charge_next_full();
      return (charge_count + 10'd1) == CHARGE_MAX;
   endfunction

   // State register.
   always_ff @(posedge debouncingclock) begin
      if (reset) r_state <= S_CHARGING;
      else       r_state <= w_state_nxt;
   end

   // Datapath: meter, blast geometry, sticky hit mask and exported box.
   always_ff @(posedge debouncingclock) begin
      if (reset) begin
         r_prev_btn     <= 1'b0;
         r_cx           <= 11'd0;
         r_cy           <= 11'd0;
         r_rad          <= 11'd0;
         r_hit_mask     <= 4'd0;
         r_hold         <= 10'd0;
         charge_count   <= 10'd0;
         ult_ready      <= 1'b0;
         ult_active     <= 1'b0;
         ult_collisions <= 4'd0;
         blast_x0       <= 10'd0;
         blast_y0       <= 10'd0;
         blast_x1       <= 10'd0;
         blast_y1       <= 10'd0;
      end else begin
         r_prev_btn <= btnult;
         ult_ready  <= (w_state_nxt == S_READY);
         ult_active <= (w_state_nxt == S_BLAST);
         case (r_state)
            S_CHARGING: begin
               if (charge_count < CHARGE_MAX) charge_count <= charge_count + 10'd1;
            end
            S_READY: begin
               if (w_press) begin
                  r_cx       <= {1'b0, xcharacter} + 11'd10;
                  r_cy       <= {1'b0, ycharacter} + 11'd10;
                  r_rad      <= STEP;
                  r_hit_mask <= 4'd0;
               end
            end
            S_BLAST: begin
               r_hit_mask     <= r_hit_mask | w_hit;
               ult_collisions <= r_hit_mask | w_hit;
               blast_x0       <= w_x0[9:0];
               blast_y0       <= w_y0[9:0];
               blast_x1       <= w_x1[9:0];
               blast_y1       <= w_y1[9:0];
               if (r_rad >= RAD_MAX) r_hold <= 10'd0;
               else                  r_rad  <= r_rad + STEP;
            end
            S_RECOVER: begin
               if (r_hold == HOLD_LAST) begin
                  ult_collisions <= 4'd0;
                  blast_x0       <= 10'd0;
                  blast_y0       <= 10'd0;
                  blast_x1       <= 10'd0;
                  blast_y1       <= 10'd0;
                  charge_count   <= 10'd0;
               end else begin
                  r_hold <= r_hold + 10'd1;
               end
            end
            default: begin
               charge_count <= 10'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ultimate_attack.sv
// Directed self-checking bench for ultimate_attack with CHARGE_TICKS=8.
module tb_ultimate_attack;

   logic       clk = 1'b0;
   logic       reset;
   logic       btnult;
   logic [1:0] cur;
   logic [9:0] xc, yc;
   logic [9:0] xm, ym, xg, yg, xs, ys, xf, yf;
   logic [9:0] charge_count;
   logic       ult_ready, ult_active;
   logic [9:0] bx0, by0, bx1, by1;
   logic [3:0] coll;

   int total = 0;
   int bad   = 0;

   ultimate_attack #(.CHARGE_TICKS(8)) dut (
      .debouncingclock (clk),
      .reset           (reset),
      .btnult          (btnult),
      .currentcharacter(cur),
      .xcharacter      (xc),
      .ycharacter      (yc),
      .xmage           (xm),
      .ymage           (ym),
      .xgunman         (xg),
      .ygunman         (yg),
      .xswordman       (xs),
      .yswordman       (ys),
      .xfistman        (xf),
      .yfistman        (yf),
      .charge_count    (charge_count),
      .ult_ready       (ult_ready),
      .ult_active      (ult_active),
      .blast_x0        (bx0),
      .blast_y0        (by0),
      .blast_x1        (bx1),
      .blast_y1        (by1),
      .ult_collisions  (coll)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (!ult_ready && n < 60) begin
         tick();
         n++;
      end
      total++;
      if (ult_ready !== 1'b1) begin
         bad++;
         $display("FAIL wait_ready: ult_ready=%0b required 1 within 60 ticks", ult_ready);
      end
   endtask

   task automatic fire();
      btnult = 1'b1;
      tick();
      btnult = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; btnult = 1'b0;
      tick(); tick();
      total++; if (charge_count !== 10'd0) begin bad++; $display("FAIL rst_charge: got %0d required 0", charge_count); end
      total++; if (ult_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %0b required 0", ult_ready); end
      total++; if (ult_active !== 1'b0) begin bad++; $display("FAIL rst_active: got %0b required 0", ult_active); end
      total++; if (coll !== 4'd0) begin bad++; $display("FAIL rst_coll: got %b required 0000", coll); end
      total++; if (bx1 !== 10'd0 || by1 !== 10'd0) begin bad++; $display("FAIL rst_box: got x1=%0d y1=%0d required 0", bx1, by1); end
      reset = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         total++; if (charge_count !== 10'(i)) begin bad++; $display("FAIL charge_ramp: got %0d required %0d", charge_count, i); end
         total++; if (ult_ready !== (i == 8)) begin bad++; $display("FAIL ready_time: tick %0d got %0b required %0b", i, ult_ready, (i == 8)); end
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (charge_count !== 10'd8 || ult_ready !== 1'b1) begin bad++; $display("FAIL charge_hold: got %0d/%0b required 8/1", charge_count, ult_ready); end
      end
   endtask

   task automatic test_held_press();
      reset = 1'b1; tick(); reset = 1'b0;
      btnult = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      total++; if (ult_ready !== 1'b1) begin bad++; $display("FAIL held_ready: got %0b required 1", ult_ready); end
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (ult_active !== 1'b0) begin bad++; $display("FAIL held_nofire: got %0b required 0", ult_active); end
      end
      btnult = 1'b0;
      tick();
      total++; if (ult_active !== 1'b0) begin bad++; $display("FAIL release_nofire: got %0b required 0", ult_active); end
      btnult = 1'b1;
      tick();
      btnult = 1'b0;
      total++; if (ult_active !== 1'b1 || ult_ready !== 1'b0) begin bad++; $display("FAIL press_fire: active/ready got %0b/%0b required 1/0", ult_active, ult_ready); end
   endtask

   task automatic test_hit_basic();
      logic [3:0] e;
      cur = 2'b00; xc = 10'd100; yc = 10'd100;
      xm = 10'd100; ym = 10'd100; xg = 10'd130; yg = 10'd100; xs = 10'd200; ys = 10'd200;
      xf = 10'd600; yf = 10'd400;
      wait_ready();
      fire();
      for (int k = 1; k <= 20; k++) begin
         tick();
         e = (k >= 11) ? 4'b0010 : 4'b0000;
         total++; if (coll !== e) begin bad++; $display("FAIL hit_basic: tick %0d got %b required %b", k, coll, e); end
         total++; if (ult_active !== (k < 20)) begin bad++; $display("FAIL blast_active: tick %0d got %0b required %0b", k, ult_active, (k < 20)); end
         total++; if (bx0 !== 10'(110 - 2 * k) || bx1 !== 10'(110 + 2 * k)) begin bad++; $display("FAIL box_mid: tick %0d got %0d..%0d required %0d..%0d", k, bx0, bx1, 110 - 2 * k, 110 + 2 * k); end
      end
      for (int j = 1; j <= 2; j++) begin
         tick();
         total++; if (coll !== 4'b0010 || bx1 !== 10'd150) begin bad++; $display("FAIL recover_hold: got %b x1=%0d required 0010 x1=150", coll, bx1); end
      end
      tick();
      total++; if (coll !== 4'd0 || bx1 !== 10'd0 || charge_count !== 10'd0) begin bad++; $display("FAIL recover_end: got %b x1=%0d cc=%0d required 0000 0 0", coll, bx1, charge_count); end
      tick();
      total++; if (charge_count !== 10'd1) begin bad++; $display("FAIL recharge: got %0d required 1", charge_count); end
   endtask

   task automatic test_corner();
      int r, ex0;
      cur = 2'b00; xc = 10'd0; yc = 10'd0; xm = 10'd0; ym = 10'd0;
      xg = 10'd600; yg = 10'd400; xs = 10'd600; ys = 10'd400; xf = 10'd300; yf = 10'd220;
      wait_ready();
      fire();
      for (int k = 1; k <= 20; k++) begin
         tick();
         r = 2 * k;
         ex0 = (10 > r) ? 10 - r : 0;
         total++; if (bx0 !== 10'(ex0) || by0 !== 10'(ex0)) begin bad++; $display("FAIL corner_lo: r=%0d got %0d,%0d required %0d", r, bx0, by0, ex0); end
         total++; if (bx1 !== 10'(10 + r) || by1 !== 10'(10 + r)) begin bad++; $display("FAIL corner_hi: r=%0d got %0d,%0d required %0d", r, bx1, by1, 10 + r); end
         total++; if (coll !== 4'd0) begin bad++; $display("FAIL corner_coll: r=%0d got %b required 0000", r, coll); end
      end
   endtask

   task automatic test_sticky();
      logic prev;
      int   edges;
      cur = 2'b00; xc = 10'd100; yc = 10'd100; xm = 10'd100; ym = 10'd100;
      xg = 10'd130; yg = 10'd100; xs = 10'd600; ys = 10'd400; xf = 10'd600; yf = 10'd400;
      wait_ready();
      fire();
      prev = 1'b0; edges = 0;
      for (int k = 1; k <= 23; k++) begin
         tick();
         if (coll[1] && !prev) edges++;
         prev = coll[1];
         if (k == 12) begin xg = 10'd250; yg = 10'd200; end
         if (k == 15) begin xg = 10'd130; yg = 10'd100; end
         if (k <= 22) begin
            total++; if (coll[1] !== (k >= 11)) begin bad++; $display("FAIL sticky_bit: tick %0d got %0b required %0b", k, coll[1], (k >= 11)); end
         end
      end
      total++; if (edges !== 1) begin bad++; $display("FAIL sticky_edges: got %0d required 1", edges); end
   endtask

   task automatic test_reset_mid();
      cur = 2'b00; xc = 10'd100; yc = 10'd100; xm = 10'd100; ym = 10'd100;
      xg = 10'd112; yg = 10'd100; xs = 10'd600; ys = 10'd400; xf = 10'd600; yf = 10'd400;
      wait_ready();
      fire();
      for (int k = 0; k < 6; k++) tick();
      total++; if (coll !== 4'b0010 || ult_active !== 1'b1) begin bad++; $display("FAIL pre_reset: got %b/%0b required 0010/1", coll, ult_active); end
      reset = 1'b1;
      tick();
      total++; if (ult_active !== 1'b0 || coll !== 4'd0) begin bad++; $display("FAIL mid_reset: active=%0b coll=%b required 0 0000", ult_active, coll); end
      total++; if (charge_count !== 10'd0 || ult_ready !== 1'b0 || bx1 !== 10'd0) begin bad++; $display("FAIL mid_reset_state: cc=%0d rdy=%0b x1=%0d required 0 0 0", charge_count, ult_ready, bx1); end
      reset = 1'b0;
      tick();
      total++; if (charge_count !== 10'd1 || ult_active !== 1'b0) begin bad++; $display("FAIL post_reset: cc=%0d active=%0b required 1 0", charge_count, ult_active); end
   endtask

   initial begin
      reset = 1'b1; btnult = 1'b0; cur = 2'b00; xc = 10'd100; yc = 10'd100;
      xm = 10'd600; ym = 10'd400; xg = 10'd600; yg = 10'd400;
      xs = 10'd600; ys = 10'd400; xf = 10'd600; yf = 10'd400;
      test_reset();
      test_held_press();
      test_hit_basic();
      test_corner();
      test_sticky();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
